// File: rtl/cac_sched_pkg.sv
// Shared types and constants for the CAC TSV launch scheduler.
package cac_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      LAUNCH = 2'd2,
      SETTLE = 2'd3
   } state_e;

   // Codebook geometry of the 16-TSV CAC variant: 14-bit index, 10000 legal words.
   localparam int DIN_W_16TSV    = 14;
   localparam int CODE_MAX_16TSV = 10000;

   // Width of the launch/reject statistics counters.
   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cac_tx_scheduler_if.sv
// Requester-side handshake plus encoder-side launch bus of the CAC scheduler.
interface cac_tx_scheduler_if
   import cac_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DIN_W = DIN_W_16TSV,
   parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*DIN_W-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic [DIN_W-1:0]       enc_data;
   logic                   enc_load;
   logic [SRC_W-1:0]       enc_src;
   logic                   busy;
   logic                   err_range;
   logic [CNT_W-1:0]       err_cnt;
   logic [CNT_W-1:0]       launch_cnt;

   // Requesters (or a bench standing in for them) drive words in.
   modport master (
      output req_valid, req_data,
      input  req_ready, enc_data, enc_load, enc_src, busy, err_range, err_cnt, launch_cnt
   );

   // The scheduler accepts words and drives the encoder side.
   modport slave (
      input  req_valid, req_data,
      output req_ready, enc_data, enc_load, enc_src, busy, err_range, err_cnt, launch_cnt
   );

endinterface

// File: rtl/cac_rr_arb.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 (mod N_REQ).
module cac_rr_arb #(
   parameter int N_REQ = 4,
   parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [SRC_W-1:0] last_grant_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [SRC_W-1:0] idx_o,
   output logic             any_o
);

   logic [SRC_W-1:0] cand;

   // Walk the requesters starting just after the previous winner; first valid one wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = SRC_W'((int'(last_grant_i) + i) % N_REQ);
         if (!any_o && req_i[cand]) begin
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            any_o         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cac_tx_scheduler.sv
// Shares one CAC encoder link between N_REQ requesters: round-robin grant,
// code-space check, single-cycle encoder load and a settle gap after each launch.
module cac_tx_scheduler
   import cac_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DIN_W      = DIN_W_16TSV,
   parameter int CODE_MAX   = CODE_MAX_16TSV,
   parameter int SETTLE_CYC = 2
) (
   input logic          clock,
   input logic          reset,
   cac_tx_scheduler_if.slave bus
);

   localparam int          SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [31:0] CODE_LIM = 32'(CODE_MAX);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;

   state_e           state_q, state_d;
   logic [DIN_W-1:0] hold_q, hold_d;
   logic [SRC_W-1:0] idx_q, idx_d;
   logic [SRC_W-1:0] last_q, last_d;
   logic [DIN_W-1:0] enc_data_q, enc_data_d;
   logic [SRC_W-1:0] enc_src_q, enc_src_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] launch_cnt_q, launch_cnt_d;

   logic [N_REQ-1:0] arb_grant;
   logic [SRC_W-1:0] arb_idx;
   logic             arb_any;
   logic [N_REQ-1:0] ready;
   logic             load;
   logic             err;
   logic [DIN_W-1:0] words [N_REQ];

   cac_rr_arb #(.N_REQ(N_REQ), .SRC_W(SRC_W)) u_arb (
      .req_i        (bus.req_valid),
      .last_grant_i (last_q),
      .grant_o      (arb_grant),
      .idx_o        (arb_idx),
      .any_o        (arb_any)
   );

   // Unpack the requester payload bus into one word per requester.
   always_comb begin
      for (int r = 0; r < N_REQ; r++) begin
         words[r] = bus.req_data[r*DIN_W +: DIN_W];
      end
   end

   // Next-state and strobe logic for the IDLE/CHECK/LAUNCH/SETTLE sequence.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      idx_d        = idx_q;
      last_d       = last_q;
      enc_data_d   = enc_data_q;
      enc_src_d    = enc_src_q;
      settle_d     = settle_q;
      err_cnt_d    = err_cnt_q;
      launch_cnt_d = launch_cnt_q;
      ready        = '0;
      load         = 1'b0;
      err          = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = reset ? '0 : arb_grant;
            if (arb_any) begin
               hold_d  = words[arb_idx];
               idx_d   = arb_idx;
               last_d  = arb_idx;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (32'(hold_q) >= CODE_LIM) begin
               err       = 1'b1;
               err_cnt_d = sat_inc(err_cnt_q);
               state_d   = IDLE;
            end else begin
               enc_data_d = hold_q;
               enc_src_d  = idx_q;
               state_d    = LAUNCH;
            end
         end
         LAUNCH: begin
            load         = 1'b1;
            launch_cnt_d = sat_inc(launch_cnt_q);
            if (SETTLE_CYC == 0) begin
               state_d = IDLE;
            end else begin
               settle_d = SETTLE_LOAD;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == '0) begin
               state_d = IDLE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any word in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         idx_q        <= '0;
         last_q       <= SRC_W'(N_REQ - 1);
         enc_data_q   <= '0;
         enc_src_q    <= '0;
         settle_q     <= '0;
         err_cnt_q    <= '0;
         launch_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         enc_data_q   <= enc_data_d;
         enc_src_q    <= enc_src_d;
         settle_q     <= settle_d;
         err_cnt_q    <= err_cnt_d;
         launch_cnt_q <= launch_cnt_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.enc_load   = load;
   assign bus.err_range  = err;
   assign bus.enc_data   = enc_data_q;
   assign bus.enc_src    = enc_src_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err_cnt    = err_cnt_q;
   assign bus.launch_cnt = launch_cnt_q;

endmodule
